// File: rtl/hdmi_period_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_period_sequencer
// Description : HDMI raster timing and period sequencer. Keeps horizontal and
//               vertical position counters on the TMDS clock and decodes them,
//               together with a one-bit island state register, into the
//               period type (control / data island / video), guard bands,
//               preambles, sync levels and per-channel control symbols.
//
// Ports
//   tmds_clk       in   TMDS character clock; all state changes on rising edge
//   n_rst          in   asynchronous active-low reset
//   island_req     in   a data island is pending upstream (sampled at S-1)
//   island_ack     out  one-cycle pulse at island start: island accepted
//   period_type    out  00 control, 01 data island, 10 video
//   guard_band     out  current cycle is a guard-band cycle
//   ctrl_ch0..2    out  control symbols per TMDS channel
//   hsync, vsync   out  active-high sync
//   pixel_req      out  active pixel cycle
//   pixel_x/y      out  horizontal / vertical counters
//   island_active  out  data-island packet cycle
//   island_idx     out  packet cycle index 0..31 (0 outside packet cycles)
//
// Legal configuration: H_ACTIVE + ISL_OFS + 44 <= H_TOTAL - 10, so the island
// always completes before the video preamble of the next line can start.
//
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_period_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ISL_OFS  = 32
) (
    input  logic        tmds_clk,
    input  logic        n_rst,
    input  logic        island_req,
    output logic        island_ack,
    output logic [1:0]  period_type,
    output logic        guard_band,
    output logic [1:0]  ctrl_ch0,
    output logic [1:0]  ctrl_ch1,
    output logic [1:0]  ctrl_ch2,
    output logic        hsync,
    output logic        vsync,
    output logic        pixel_req,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        island_active,
    output logic [4:0]  island_idx
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int ISL_S   = H_ACTIVE + ISL_OFS;

    // Raster boundaries as 12-bit constants so every compare is width-matched.
    localparam logic [11:0] c_h_last   = 12'(H_TOTAL - 1);
    localparam logic [11:0] c_v_last   = 12'(V_TOTAL - 1);
    localparam logic [11:0] c_h_act    = 12'(H_ACTIVE);
    localparam logic [11:0] c_v_act    = 12'(V_ACTIVE);
    localparam logic [11:0] c_hs_beg   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_vs_beg   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] c_vpre_beg = 12'(H_TOTAL - 10);
    localparam logic [11:0] c_vgb_beg  = 12'(H_TOTAL - 2);

    // Data island landmarks relative to the start point S.
    localparam logic [11:0] c_isl_arm  = 12'(ISL_S - 1);
    localparam logic [11:0] c_isl_s    = 12'(ISL_S);
    localparam logic [11:0] c_isl_gb0  = 12'(ISL_S + 8);
    localparam logic [11:0] c_isl_pk   = 12'(ISL_S + 10);
    localparam logic [11:0] c_isl_gb1  = 12'(ISL_S + 42);
    localparam logic [11:0] c_isl_last = 12'(ISL_S + 43);
    localparam logic [4:0]  c_isl_pk5  = 5'(ISL_S + 10);

    typedef enum logic [0:0] {
        ISL_IDLE = 1'b0,
        ISL_BUSY = 1'b1
    } isl_state_t;

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    isl_state_t  r_isl_state;
    isl_state_t  w_isl_next;

    logic [11:0] w_v_next;
    logic        w_next_line_active;
    logic        w_video_active;
    logic        w_hsync;
    logic        w_vsync;

    // ------------------------------------------------------------------------
    // Raster counters. Reset parks the beam at the start of the horizontal
    // blank of the last line, so the first line after release is line 0 and
    // it is preceded by its complete preamble and guard band.
    // ------------------------------------------------------------------------
    always_ff @(posedge tmds_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_h_cnt <= c_h_act;
            r_v_cnt <= c_v_last;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Island state register. The request is looked at only on the edge that
    // leaves h_cnt == S-1; any other request cycle is ignored. Once accepted,
    // the island runs to S+43 on its own, so one island per line at most.
    // ------------------------------------------------------------------------
    always_ff @(posedge tmds_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_isl_state <= ISL_IDLE;
        end else begin
            r_isl_state <= w_isl_next;
        end
    end

    always_comb begin
        w_isl_next = r_isl_state;
        case (r_isl_state)
            ISL_IDLE: begin
                if ((r_h_cnt == c_isl_arm) && island_req) begin
                    w_isl_next = ISL_BUSY;
                end
            end
            ISL_BUSY: begin
                if (r_h_cnt == c_isl_last) begin
                    w_isl_next = ISL_IDLE;
                end
            end
            default: w_isl_next = ISL_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Decodes of the registered position. The preamble and guard band at the
    // end of a line belong to the following line, hence the look-ahead on
    // the vertical counter (the last line announces line 0).
    // ------------------------------------------------------------------------
    assign w_v_next           = (r_v_cnt == c_v_last) ? 12'd0 : r_v_cnt + 12'd1;
    assign w_next_line_active = (w_v_next < c_v_act);
    assign w_video_active     = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hsync            = (r_h_cnt >= c_hs_beg) && (r_h_cnt < c_hs_end);
    assign w_vsync            = (r_v_cnt >= c_vs_beg) && (r_v_cnt < c_vs_end);

    always_comb begin
        period_type   = 2'b00;
        guard_band    = 1'b0;
        ctrl_ch1      = 2'b00;
        ctrl_ch2      = 2'b00;
        pixel_req     = 1'b0;
        island_ack    = 1'b0;
        island_active = 1'b0;
        island_idx    = 5'd0;

        if (w_video_active) begin
            period_type = 2'b10;
            pixel_req   = 1'b1;
        end else if (w_next_line_active && (r_h_cnt >= c_vpre_beg) &&
                     (r_h_cnt < c_vgb_beg)) begin
            // Video preamble: CTL0 set on channel 1, channel 2 idle.
            ctrl_ch1 = 2'b01;
        end else if (w_next_line_active && (r_h_cnt >= c_vgb_beg)) begin
            period_type = 2'b10;
            guard_band  = 1'b1;
        end else if (r_isl_state == ISL_BUSY) begin
            // The busy state only spans S..S+43, so these ranges are enough.
            island_ack = (r_h_cnt == c_isl_s);
            if (r_h_cnt < c_isl_gb0) begin
                // Island preamble: CTL0 on channel 1 and CTL2 on channel 2.
                ctrl_ch1 = 2'b01;
                ctrl_ch2 = 2'b01;
            end else if ((r_h_cnt < c_isl_pk) || (r_h_cnt >= c_isl_gb1)) begin
                period_type = 2'b01;
                guard_band  = 1'b1;
            end else begin
                period_type   = 2'b01;
                island_active = 1'b1;
                // 32 packet cycles, so modulo-32 subtraction gives the index.
                island_idx    = r_h_cnt[4:0] - c_isl_pk5;
            end
        end
    end

    // Sync and channel-0 symbols never depend on island or preamble state.
    assign hsync    = w_hsync;
    assign vsync    = w_vsync;
    assign ctrl_ch0 = {w_vsync, w_hsync};
    assign pixel_x  = r_h_cnt;
    assign pixel_y  = r_v_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_period_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_period_sequencer
// Description : Scoreboard bench for hdmi_period_sequencer on a reduced
//               raster. A driver issues island requests (random per-line
//               patterns) and resets, advances a reference raster model and
//               queues the expected outputs; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_period_sequencer;

    localparam int H_ACTIVE = 32;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 24;
    localparam int H_BP     = 40;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 4;
    localparam int ISL_OFS  = 8;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int S        = H_ACTIVE + ISL_OFS;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic        clk;
    logic        n_rst;
    logic        island_req;
    logic        island_ack;
    logic [1:0]  period_type;
    logic        guard_band;
    logic [1:0]  ctrl_ch0;
    logic [1:0]  ctrl_ch1;
    logic [1:0]  ctrl_ch2;
    logic        hsync;
    logic        vsync;
    logic        pixel_req;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        island_active;
    logic [4:0]  island_idx;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: beam position and "island granted on this line".
    int mh;
    int mv;
    bit mg;
    logic [42:0] expq[$];

    hdmi_period_sequencer #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .ISL_OFS(ISL_OFS)
    ) dut (
        .tmds_clk     (clk),
        .n_rst        (n_rst),
        .island_req   (island_req),
        .island_ack   (island_ack),
        .period_type  (period_type),
        .guard_band   (guard_band),
        .ctrl_ch0     (ctrl_ch0),
        .ctrl_ch1     (ctrl_ch1),
        .ctrl_ch2     (ctrl_ch2),
        .hsync        (hsync),
        .vsync        (vsync),
        .pixel_req    (pixel_req),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .island_active(island_active),
        .island_idx   (island_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for beam position (h,v), given whether an island was
    // granted on this line.
    function automatic logic [42:0] exp_vec(int h, int v, bit g);
        logic       ack, gb, hs, vs, pix, ia;
        logic [1:0] pt, c1, c2;
        logic [4:0] idx;
        int nl, off;
        ack = 0; gb = 0; pix = 0; ia = 0; pt = 2'b00; c1 = 2'b00; c2 = 2'b00; idx = 5'd0;
        hs = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
        vs = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
        nl = (v + 1) % V_TOTAL;
        if (h < H_ACTIVE && v < V_ACTIVE) begin
            pt = 2'b10; pix = 1;
        end else if (nl < V_ACTIVE && h >= H_TOTAL - 10 && h < H_TOTAL - 2) begin
            c1 = 2'b01;
        end else if (nl < V_ACTIVE && h >= H_TOTAL - 2) begin
            pt = 2'b10; gb = 1;
        end else if (g && h >= S && h < S + 44) begin
            off = h - S;
            ack = (off == 0);
            if (off < 8) begin
                c1 = 2'b01; c2 = 2'b01;
            end else if (off < 10 || off >= 42) begin
                pt = 2'b01; gb = 1;
            end else begin
                pt = 2'b01; ia = 1; idx = 5'(off - 10);
            end
        end
        return {ack, pt, gb, vs, hs, c1, c2, hs, vs, pix, 12'(h), 12'(v), ia, idx};
    endfunction

    task automatic check(input logic [42:0] e, input string name);
        logic [42:0] act;
        act = {island_ack, period_type, guard_band, ctrl_ch0, ctrl_ch1, ctrl_ch2,
               hsync, vsync, pixel_req, pixel_x, pixel_y, island_active, island_idx};
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s h=%0d v=%0d: got %h want %h", name,
                     e[17:6], e[5:0] == 6'd0 ? e[17:6] : e[17:6], act, e);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, advance the model to
    // the state the DUT will hold after the next rising edge, queue it.
    task automatic step(input bit req, input bit rst_low);
        @(negedge clk);
        island_req = req;
        if (rst_low) begin
            n_rst = 1'b0;
            mh = H_ACTIVE; mv = V_TOTAL - 1; mg = 0;
            #1;
            check(exp_vec(mh, mv, mg), "reset_async");
        end else begin
            n_rst = 1'b1;
            if (mh == S - 1 && req) mg = 1;
            mh++;
            if (mh == H_TOTAL) begin
                mh = 0; mg = 0; mv = (mv + 1) % V_TOTAL;
            end
        end
        expq.push_back(exp_vec(mh, mv, mg));
    endtask

    // Random per-line request pattern: none, exact pulse at S-1, held high,
    // random each cycle, or a single pulse away from S-1.
    int mode = 0;
    int pos  = 0;

    task automatic run_random(input int cycles, input bit allow);
        bit r;
        for (int c = 0; c < cycles; c++) begin
            if (mh == 0) begin
                mode = allow ? int'($urandom_range(0, 4)) : 0;
                pos  = int'($urandom_range(0, H_TOTAL - 1));
                if (pos == S - 1) pos = S;
            end
            case (mode)
                1:       r = (mh == S - 1);
                2:       r = 1'b1;
                3:       r = 1'($urandom % 2);
                4:       r = (mh == pos);
                default: r = 1'b0;
            endcase
            step(r, 1'b0);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queue head.
    initial begin
        logic [42:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check(e, "outputs");
            end
        end
    end

    initial begin
        bit hit;
        n_rst      = 1'b0;
        island_req = 1'b0;
        mh = H_ACTIVE; mv = V_TOTAL - 1; mg = 0;
        repeat (4) step(1'b0, 1'b1);

        // Reset release with no requests first, then randomized frames.
        run_random(FRAME, 1'b0);
        run_random(3 * FRAME, 1'b1);

        // Request an island and reset in the middle of its packet cycles.
        hit = 0;
        for (int c = 0; c < 3 * H_TOTAL; c++) begin
            if (mg && mh == S + 20) begin
                hit = 1;
                break;
            end
            step(mh == S - 1, 1'b0);
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL island_setup_timeout: got no island, want island granted");
        end
        repeat (3) step(1'b0, 1'b1);

        // No island may appear after the aborted one unless re-requested.
        run_random(2 * FRAME, 1'b0);
        run_random(FRAME, 1'b1);

        for (int c = 0; c < 10 && expq.size() > 0; c++) @(posedge clk);
        #2;
        if (expq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
